encoder_serial4to2: RTL
=======================

// Module: encoder_serial4to2
// PURPOSE
//  Sequential counterpart to the team's 2-to-4 decoder: converts a multi-hot request
//  vector back into binary indices. Accepts an N-bit vector, then emits the index of
//  each set bit, lowest first, one per valid/ready handshake. Used wherever a
//  decoded/one-hot status word must be serialised into binary codes for a consumer.
// PARAMETERS
//  N   4   input vector width (number of decoded lines)
//  W   2   output index width, W = clog2(N); N = 2**W required
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    in_vec valid this cycle
//  in_ready   out  1    block idle, vector accepted when in_valid & in_ready
//  in_vec     in   N    multi-hot vector; bit k set = index k to emit
//  out_valid  out  1    out_idx valid
//  out_ready  in   1    consumer takes out_idx when out_valid & out_ready
//  out_idx    out  W    binary index of lowest pending set bit
//  out_last   out  1    out_idx is the final pending index of this vector
//  out_cnt    out  W+1  indices emitted so far for current vector
//  zero_flag  out  1    one-cycle pulse: an all-zero vector was accepted
// BEHAVIOUR
//  - State: pending[N-1:0] register, 2-state FSM IDLE/BUSY, out_cnt register.
//  - Reset (async, rst_n=0): FSM=IDLE, pending=0, out_cnt=0, zero_flag=0;
//    hence in_ready=1, out_valid=0, out_idx=0, out_last=0. Reset mid-vector discards
//    all pending indices; no partial output after rst_n rises.
//  - in_ready = (FSM==IDLE). out_valid = (FSM==BUSY). Combinational from registers.
//  - IDLE: on in_valid & in_vec!=0 at edge k: pending<=in_vec, out_cnt<=0, FSM<=BUSY;
//    out_valid high from cycle k+1 (latency 1). on in_valid & in_vec==0: stay IDLE,
//    zero_flag=1 for cycle k+1 only. in_valid=0: hold.
//  - BUSY: out_idx = index of lowest set bit of pending (priority encode, bit 0 wins).
//    out_last = (exactly one bit of pending set).
//    On handshake: clear that bit in pending, out_cnt<=out_cnt+1; if out_last,
//    FSM<=IDLE. Throughput: one index per cycle under out_ready=1.
//  - Backpressure: out_ready=0 holds out_idx, out_last, out_cnt stable; out_valid stays 1.
//  - in_valid while BUSY: ignored (in_ready=0), vector not captured.
//  - After last handshake at edge j, in_ready=1 in cycle j+1 (one-cycle IDLE bubble
//    between vectors, by design). out_cnt holds its final value in IDLE until next load.
//  - Output never carries an index whose bit was 0 in the accepted vector; each set
//    bit emitted exactly once, ascending order.
//  - out_cnt width W+1 holds max value N without wrap.
// TESTING
//  1. in_vec=4'b1010, out_ready=1 -> out_idx 1 (last=0) then 3 (last=1); in_ready=1
//     next cycle; out_cnt=2.
//  2. in_vec=4'b1111, out_ready=1 -> idx 0,1,2,3 on 4 consecutive cycles, last only on 3,
//     out_cnt=4.
//  3. in_vec=4'b0110, out_ready low 3 cycles -> out_idx=1 held stable, out_valid=1;
//     release -> 1 then 2.
//  4. in_vec=4'b0000 accepted -> zero_flag one-cycle pulse, out_valid stays 0,
//     in_ready stays 1.
//  5. in_vec=4'b1001 loaded, new in_valid with 4'b0100 while BUSY -> ignored; only
//     0 and 3 emitted.
//  6. Load 4'b1110, pull rst_n low after first handshake -> immediate IDLE, out_valid=0,
//     out_cnt=0; no further indices after release.

Source files
------------

// File: rtl/encoder_serial4to2.sv
// Serialises a multi-hot request vector into binary indices, lowest set bit first.
// Latency: first index valid the cycle after acceptance; one index per cycle after that.
// Backpressure: out_ready=0 freezes out_idx/out_last/out_cnt; in_ready stays low while busy.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     vector handshake (in_ready = idle)
//   in_vec[N-1:0]         multi-hot vector, bit k set = emit index k
//   out_valid/out_ready   index handshake
//   out_idx[W-1:0]        lowest pending index
//   out_last              out_idx is the final pending index of the vector
//   out_cnt[W:0]          indices emitted so far for the current vector
//   zero_flag             one-cycle pulse after an all-zero vector is accepted
module encoder_serial4to2 #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic [W:0]   out_cnt,
  output logic         zero_flag
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] pending;
  logic         load;
  logic         zero_load;
  logic         take;

  // An all-zero vector is consumed in IDLE but never enters BUSY.
  assign load      = (state == IDLE) && in_valid && (in_vec != '0);
  assign zero_load = (state == IDLE) && in_valid && (in_vec == '0);
  assign take      = (state == BUSY) && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = BUSY;
      BUSY: if (take && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == BUSY);
  end

  // Priority encoder: scanning downward lets the lowest set bit win.
  always_comb begin
    out_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) out_idx = W'(i);
    end
  end

  // Exactly one bit pending: non-zero and a power of two.
  assign out_last = (pending != '0) && ((pending & (pending - N'(1))) == '0);

  // Datapath: pending bits, emitted count, zero-vector pulse.
  // pending drains to zero on the last handshake, so out_idx/out_last read 0 in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_cnt   <= '0;
      zero_flag <= 1'b0;
    end else begin
      zero_flag <= zero_load;
      if (load) begin
        pending <= in_vec;
        out_cnt <= '0;
      end else if (take) begin
        pending <= pending & ~(N'(1) << out_idx);
        out_cnt <= out_cnt + (W + 1)'(1);
      end
    end
  end

endmodule
